// File: rtl/ram_hs_if.sv
// Request/response bus for ram_hs: one request in flight, one response per accepted request.
// A transfer happens on a rising edge where valid and ready are both 1. valid must stay high with stable payload until that edge.
interface ram_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_hs.sv
// Single-port data memory with request/response handshake, byte strobes, fixed read latency
// and optional zero-fill after reset. Bad addresses get an error response, never an alias.
module ram_hs #(
  parameter int              DATA_W         = 32,
  parameter int              ADDR_W         = 32,
  parameter int              DEPTH          = 1024,
  parameter int              LATENCY        = 1,
  parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(32'h8000_0000),
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  ram_hs_if.slave    bus,
  output logic [1:0] o_dbg_state
);

  localparam int BYTES   = DATA_W / 8;
  localparam int OFF_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0]   SPAN       = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_clr_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_off;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;
  logic                w_hs;
  logic                w_clr_we;
  logic                w_wr_we;

  // Subtraction wraps, so addresses below BASE land on a huge offset and fail the range test.
  assign w_off    = bus.req_addr - BASE;
  assign w_err    = ((w_off & ALIGN_MASK) != '0) || ({1'b0, w_off} >= SPAN);
  assign w_idx    = w_off[OFF_LSB +: IDX_W];
  assign w_hs     = bus.req_valid && r_req_ready && (r_state == S_IDLE);
  assign w_clr_we = reset_n && (r_state == S_CLEAR);
  assign w_wr_we  = reset_n && w_hs && bus.req_wen && !w_err;

  // Array has no reset so its contents survive a reset pulse when no clear is run.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_req_ready  <= !CLEAR_ON_RESET;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_clr_idx    <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            r_req_ready  <= 1'b0;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || bus.req_wen) ? '0 : r_mem[w_idx];
            r_cnt        <= '0;
            if (LATENCY > 1) begin
              r_state <= S_BUSY;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(LATENCY - 2)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ram_hs.sv
// Scoreboarded bench for ram_hs: a clearing instance and a non-clearing instance,
// both checked against an array model of the byte-addressed memory window.
module tb_ram_hs;
  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 32;
  localparam int          DEPTH   = 16;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n  = 1'b1;
  logic rst_n_nc = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  ram_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  ram_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) nb ();
  logic [1:0] dbg0, dbg1;

  ram_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
           .BASE(BASE), .CLEAR_ON_RESET(1'b1))
    u_dut (.clk(clk), .reset_n(reset_n), .bus(bus), .o_dbg_state(dbg0));

  ram_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
           .BASE(BASE), .CLEAR_ON_RESET(1'b0))
    u_dut_nc (.clk(clk), .reset_n(rst_n_nc), .bus(nb), .o_dbg_state(dbg1));

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] e0, e1;
  logic [31:0] model_mem[2][DEPTH];
  bit          stall_en = 1'b0;
  int          hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte window [BASE, BASE+DEPTH*4), word aligned; anything else is an error.
  function automatic logic [32:0] model_access(input int d, input bit wen, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] off;
    int w;
    off = addr - BASE;
    if ((off % 4) != 0 || off >= 32'(DEPTH * 4)) return {1'b1, 32'h0};
    w = int'(off / 4);
    if (wen) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[d][w][8*b +: 8] = wdata[8*b +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, model_mem[d][w]};
  endfunction

  // monitors
  always @(negedge clk) begin
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q0.size() == 0) chk($sformatf("resp0_unexpected st=%0d", dbg0), 64'd1, 64'd0);
      else begin
        e0 = exp_q0.pop_front();
        chk($sformatf("resp0 st=%0d", dbg0), {31'b0, bus.resp_err, bus.resp_rdata}, {31'b0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_nc && nb.resp_valid && nb.resp_ready) begin
      if (exp_q1.size() == 0) chk($sformatf("resp1_unexpected st=%0d", dbg1), 64'd1, 64'd0);
      else begin
        e1 = exp_q1.pop_front();
        chk($sformatf("resp1 st=%0d", dbg1), {31'b0, nb.resp_err, nb.resp_rdata}, {31'b0, e1});
      end
    end
  end

  always @(posedge clk) begin
    if (stall_en) begin
      #1;
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks
  task automatic drive_req(input bit nc, input bit wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    int   n;
    logic rdy;
    n = 0;
    if (nc) begin
      nb.req_valid = 1'b1; nb.req_wen = wen; nb.req_addr = addr;
      nb.req_wdata = wdata; nb.req_wstrb = strb;
    end else begin
      bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_wstrb = strb;
    end
    rdy = 1'b0;
    while (!rdy) begin
      @(negedge clk);
      rdy = nc ? nb.req_ready : bus.req_ready;
      n++;
      if (!rdy && n > 300) begin
        checks++; errors++;
        $display("FAIL req_timeout: got no req_ready expected 1 addr=0x%0h", addr);
        bus.req_valid = 1'b0; nb.req_valid = 1'b0;
        return;
      end
    end
    if (nc) exp_q1.push_back(model_access(1, wen, addr, wdata, strb));
    else    exp_q0.push_back(model_access(0, wen, addr, wdata, strb));
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (nc) nb.req_valid = 1'b0; else bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset on the clearing instance, checks async reset values, then times the fill.
  task automatic reset_main();
    int n;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    exp_q0.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[0][i] = '0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.req_ready || n > 100) break;
    end
    chk("clear_edges", 64'(n), 64'(DEPTH));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int          n;
    int          kind;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] v;

    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = 1'b1;
    nb.req_valid = 1'b0; nb.req_wen = 1'b0; nb.req_addr = '0;
    nb.req_wdata = '0; nb.req_wstrb = '0; nb.resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[1][i] = '0;

    #2;
    rst_n_nc = 1'b0;
    reset_main();

    // read after clear, then strobed read-modify-write
    drive_req(0, 0, BASE + 32'h4, 32'h0, 4'h0);
    drive_req(0, 1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
    drive_req(0, 1, BASE + 32'h8, 32'h0055_0000, 4'h4);
    drive_req(0, 0, BASE + 32'h8, 32'h0, 4'h0);
    wait_drain();

    // latency and back-pressure with a concurrent (ignored) request
    bus.resp_ready = 1'b0;
    drive_req(0, 0, BASE + 32'h8, 32'h0, 4'h0);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid || n > 50) break;
    end
    chk("latency", 64'(cyc + 1 - hs_cyc), 64'(LATENCY));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = BASE + 32'h8;
    bus.req_wdata = 32'hFFFF_FFFF; bus.req_wstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_rdata", 64'(bus.resp_rdata), 64'(model_mem[0][2]));
      chk("stall_err", 64'(bus.resp_err), 64'd0);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    drive_req(0, 0, BASE + 32'h8, 32'h0, 4'h0);

    // address boundaries
    drive_req(0, 0, BASE + 32'h3C, 32'h0, 4'h0);
    drive_req(0, 0, BASE + 32'h40, 32'h0, 4'h0);
    drive_req(0, 1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF);
    drive_req(0, 0, BASE, 32'h0, 4'h0);
    drive_req(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    drive_req(0, 1, BASE + 32'h3C, 32'hA0B1_C2D3, 4'hF);
    drive_req(0, 0, BASE + 32'h3C, 32'h0, 4'h0);
    wait_drain();

    // randomized traffic with random response stalls
    stall_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      wen  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      if (kind == 8) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 9) addr = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 4) * 4)
                                                        : BASE + 32'(DEPTH * 4 + $urandom_range(0, 8) * 4);
      drive_req(0, wen, addr, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_drain();
    stall_en = 1'b0;
    @(posedge clk);
    #2;
    bus.resp_ready = 1'b1;

    // reset while BUSY: response dropped, clear re-runs
    drive_req(0, 1, BASE + 32'h10, 32'h1234_5678, 4'hF);
    drive_req(0, 0, BASE + 32'h10, 32'h0, 4'h0);
    reset_main();
    drive_req(0, 0, BASE + 32'h10, 32'h0, 4'h0);
    wait_drain();

    // reset while RESP (mid-cycle): outputs drop without a clock edge
    drive_req(0, 1, BASE + 32'h10, 32'h1234_5678, 4'hF);
    wait_drain();
    bus.resp_ready = 1'b0;
    drive_req(0, 0, BASE + 32'h10, 32'h0, 4'h0);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid || n > 50) break;
    end
    chk("resp_before_rst", 64'(bus.resp_valid), 64'd1);
    #1;
    reset_main();
    bus.resp_ready = 1'b1;
    drive_req(0, 0, BASE + 32'h10, 32'h0, 4'h0);
    wait_drain();

    // non-clearing instance: ready during reset, contents survive a reset pulse
    chk("nc_ready_in_reset", 64'(nb.req_ready), 64'd1);
    chk("nc_valid_in_reset", 64'(nb.resp_valid), 64'd0);
    rst_n_nc = 1'b1;
    v = $urandom;
    drive_req(1, 1, BASE + 32'h14, v, 4'hF);
    drive_req(1, 1, BASE + 32'h14, $urandom, 4'h1);
    drive_req(1, 0, BASE + 32'h14, 32'h0, 4'h0);
    wait_drain();
    rst_n_nc = 1'b0;
    #1;
    chk("nc_ready_pulse", 64'(nb.req_ready), 64'd1);
    chk("nc_valid_pulse", 64'(nb.resp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n_nc = 1'b1;
    drive_req(1, 0, BASE + 32'h14, 32'h0, 4'h0);
    drive_req(1, 0, BASE + 32'h80, 32'h0, 4'h0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
